// File: rtl/vga_timing_gen.sv
// Pixel-clock raster timing generator: line/frame counters plus registered
// syncs, blanking, display enable and start pulses, all advanced by ce.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CNT_W      = 10
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             ce,
  output logic             h_sync,
  output logic             v_sync,
  output logic             display_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             line_start,
  output logic             frame_start,
  output logic             v_blank,
  output logic [7:0]       frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic [7:0]       frame;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_sync_region;
  logic             v_sync_region;

  assign h_wrap        = (h == H_LAST);
  assign v_wrap        = (v == V_LAST);
  assign h_sync_region = (h >= H_SYNC_LO) && (h < H_SYNC_HI);
  assign v_sync_region = (v >= V_SYNC_LO) && (v < V_SYNC_HI);

  // Outputs describe the position held in h/v at the ce edge, so every output
  // comes from the same counter value and they never skew against each other.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      h           <= '0;
      v           <= '0;
      frame       <= '0;
      h_count     <= '0;
      v_count     <= '0;
      display_en  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      v_blank     <= 1'b0;
      frame_count <= '0;
      h_sync      <= ~H_SYNC_POL;
      v_sync      <= ~V_SYNC_POL;
    end else if (ce) begin
      h_count     <= h;
      v_count     <= v;
      display_en  <= (h < H_ACT) && (v < V_ACT);
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
      v_blank     <= (v >= V_ACT);
      frame_count <= frame;
      h_sync      <= h_sync_region ? H_SYNC_POL : ~H_SYNC_POL;
      v_sync      <= v_sync_region ? V_SYNC_POL : ~V_SYNC_POL;

      if (h_wrap) begin
        h <= '0;
        if (v_wrap) begin
          v     <= '0;
          frame <= frame + 8'd1;
        end else begin
          v <= v + 1'b1;
        end
      end else begin
        h <= h + 1'b1;
      end
    end
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16; H_SYNC, default 96; H_BP, default 48: horizontal front porch, sync and back porch, in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP, default 10; V_SYNC, default 2; V_BP, default 33: vertical porches and sync, in lines.
REQ-005 Parameter H_SYNC_POL, default 0; V_SYNC_POL, default 0: asserted sync level (0 = active-low).
REQ-006 Parameter CNT_W, default 10: counter width; must satisfy 2^CNT_W >= max(H_TOTAL, V_TOTAL).
REQ-007 clk_in  input  1  pixel clock; single clock domain; the block contains no PLL.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 ce  input  1  pixel enable; the block advances only on cycles where ce=1.
REQ-010 h_sync  output  1  horizontal sync at the configured polarity.
REQ-011 v_sync  output  1  vertical sync at the configured polarity.
REQ-012 display_en  output  1  high while the current pixel is inside the active area.
REQ-013 h_count  output  CNT_W  horizontal position of the current pixel.
REQ-014 v_count  output  CNT_W  vertical position of the current pixel.
REQ-015 line_start  output  1  one-ce pulse on pixel (0, any line).
REQ-016 frame_start  output  1  one-ce pulse on pixel (0,0).
REQ-017 v_blank  output  1  high for lines v >= V_ACTIVE.
REQ-018 frame_count  output  8  frame counter; wraps modulo 256.

Function
REQ-019 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP shall be derived from the parameters and shall not be separate parameters.
REQ-020 The internal h counter shall count 0..H_TOTAL-1 and return to 0 after H_TOTAL-1, giving exactly H_TOTAL positions per line.
REQ-021 The internal v counter shall increment only on the cycle where h wraps, shall count 0..V_TOTAL-1, and shall wrap to 0 after V_TOTAL-1 (exactly V_TOTAL lines).
REQ-022 When ce=0, the counters and all outputs shall hold their values; line_start and frame_start shall be qualified by ce so that each pulses for exactly one ce cycle.
REQ-023 All outputs shall be registered, driven from the same internal counter value, and valid one clk_in cycle after the ce cycle in which that value was current; there shall be no skew between outputs.
REQ-024 h_sync shall be asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. exactly H_SYNC pixels.
REQ-025 v_sync shall be asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. exactly V_SYNC whole lines; it shall change on h wrap.
REQ-026 display_en shall be 1 iff h < H_ACTIVE and v < V_ACTIVE.
REQ-027 frame_count shall increment by 1 together with frame_start and shall wrap from 255 to 0.
REQ-028 Simultaneous h wrap and v wrap shall produce h=0, v=0, line_start=1, frame_start=1 and a frame_count increment on the same output cycle.
REQ-029 ce=1 on every cycle shall give the standard 640x480@60 timing: 800x525 = 420000 cycles per frame.

Reset
REQ-030 While reset=1 on a clk_in edge, the internal counters shall be set to 0 regardless of ce.
REQ-031 During reset, outputs shall be: h_count=0, v_count=0, display_en=0, line_start=0, frame_start=0, v_blank=0, frame_count=0, h_sync=!H_SYNC_POL, v_sync=!V_SYNC_POL.
REQ-032 On the first ce cycle after reset deasserts, the outputs shall show pixel (0,0) with frame_start=1, line_start=1, display_en=1, and frame_count shall remain 0.
REQ-033 Reset asserted mid-frame shall abort the frame with no partial sync pulse after the reset edge.

Verification
REQ-034 Defaults, ce=1, reset released -> h_sync low exactly for h_count 656..751; period 800 cycles; 96 low cycles per line.
REQ-035 Defaults, ce=1 for 2 frames -> v_sync low exactly for v_count 490..491 (1600 cycles); frame_start spacing 420000 cycles; frame_count 0->1->2.
REQ-036 ce toggling 1,0,1,0 -> each h_count value held for 2 cycles; line_start high for exactly 1 ce cycle; frame period 840000 cycles.
REQ-037 Reset pulse at h=700, v=300 -> next output cycle has h_count=0, v_count=0, h_sync=1, v_sync=1, display_en=0; the first ce after release gives frame_start=1.
REQ-038 Parameters H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, H_SYNC_POL=1, CNT_W=4 -> 12x7 = 84-cycle frame; h_sync high for h 9..10; display_en high for 32 cycles per frame.
REQ-039 Run 256 frames on the small configuration -> frame_count wraps 255->0 together with frame_start.
